// File: rtl/adder_err_eval.sv
// Error evaluator for a 4+4-bit approximate adder: accumulates error count, SAE and max error distance.
// Define ADDER_ERR_EVAL_MSE_EN to add the sse output (sum of squared error distances).
module adder_err_eval #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_pi,
  input  logic [4:0]         in_po,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W+4:0]   sae,
  output logic [4:0]         max_ed
`ifdef ADDER_ERR_EVAL_MSE_EN
  ,
  output logic [CNT_W+9:0]   sse
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic             s1_valid;
  logic [4:0]       s1_ed;
  logic             s1_err;

  logic       handshake;
  logic       start_take;
  logic [4:0] exact;
  logic [4:0] ed;

  assign exact      = {1'b0, in_pi[3:0]} + {1'b0, in_pi[7:4]};
  assign ed         = (exact >= in_po) ? (exact - in_po) : (in_po - exact);
  assign handshake  = in_valid && in_ready;
  assign start_take = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero-length run skips RUN/DRAIN; DRAIN waits until stage 1 has emptied into the accumulators.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (handshake && ((acc_cnt + CNT_W'(1)) == n_lat)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = (acc_cnt < n_lat);
        busy     = 1'b1;
      end
      DRAIN: busy = 1'b1;
      DONE:  done = 1'b1;
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat    <= '0;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
      s1_ed    <= '0;
      s1_err   <= 1'b0;
    end else if (start_take) begin
      n_lat    <= num_samples;
      acc_cnt  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= handshake;
      if (handshake) begin
        s1_ed   <= ed;
        s1_err  <= (exact != in_po);
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
    end
  end

  // Stage 2: fold the registered sample into the accumulators.
  always_ff @(posedge clk) begin
    if (rst || start_take) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sae        <= '0;
      max_ed     <= '0;
    end else if (s1_valid) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      err_cnt    <= err_cnt + CNT_W'(s1_err);
      sae        <= sae + (CNT_W+5)'(s1_ed);
      if (s1_ed > max_ed) begin
        max_ed <= s1_ed;
      end
    end
  end

`ifdef ADDER_ERR_EVAL_MSE_EN
  logic [9:0] ed_sq;

  assign ed_sq = {5'd0, s1_ed} * {5'd0, s1_ed};

  always_ff @(posedge clk) begin
    if (rst || start_take) begin
      sse <= '0;
    end else if (s1_valid) begin
      sse <= sse + (CNT_W+10)'(ed_sq);
    end
  end
`endif

endmodule

// File: tb/tb_adder_err_eval.sv
// Directed self-checking bench for adder_err_eval; each task drives one scenario and checks inline.
module tb_adder_err_eval;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_pi;
  logic [4:0]       in_po;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W+4:0] sae;
  logic [4:0]       max_ed;
`ifdef ADDER_ERR_EVAL_MSE_EN
  logic [CNT_W+9:0] sse;
`endif

  int checks;
  int failures;

  adder_err_eval #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_samples(num_samples),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pi      (in_pi),
    .in_po      (in_po),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sae        (sae),
    .max_ed     (max_ed)
`ifdef ADDER_ERR_EVAL_MSE_EN
    ,
    .sse        (sse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    start       = 1'b1;
    num_samples = n;
    tick();
    start       = 1'b0;
  endtask

  // Presents one sample and returns just after the edge on which it was accepted.
  task automatic send_sample(input logic [7:0] pi, input logic [4:0] po);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_pi    = pi;
    in_po    = po;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("[TB] FAIL send_timeout in_ready=%0b required=1", in_ready);
    end else begin
      tick();
    end
  endtask

  task automatic wait_done();
    int waited;
    waited = 0;
    while (!done && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL wait_done done=%0b required=1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks += 7;
    if (in_ready !== 1'b0)   begin failures++; $display("[TB] FAIL rst_in_ready got=%0b exp=0", in_ready); end
    if (busy !== 1'b0)       begin failures++; $display("[TB] FAIL rst_busy got=%0b exp=0", busy); end
    if (done !== 1'b0)       begin failures++; $display("[TB] FAIL rst_done got=%0b exp=0", done); end
    if (sample_cnt !== '0)   begin failures++; $display("[TB] FAIL rst_sample_cnt got=%0d exp=0", sample_cnt); end
    if (err_cnt !== '0)      begin failures++; $display("[TB] FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
    if (sae !== '0)          begin failures++; $display("[TB] FAIL rst_sae got=%0d exp=0", sae); end
    if (max_ed !== '0)       begin failures++; $display("[TB] FAIL rst_max_ed got=%0d exp=0", max_ed); end
  endtask

  task automatic test_exact();
    pulse_start(16'd4);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL exact_busy got=%0b exp=1", busy); end
    send_sample(8'hE1, 5'd15);
    send_sample(8'h9B, 5'd20);
    send_sample(8'hAD, 5'd23);
    send_sample(8'hEF, 5'd29);
    in_valid = 1'b0;
    wait_done();
    checks += 4;
    if (sample_cnt !== 16'd4) begin failures++; $display("[TB] FAIL exact_sample_cnt got=%0d exp=4", sample_cnt); end
    if (err_cnt !== 16'd0)    begin failures++; $display("[TB] FAIL exact_err_cnt got=%0d exp=0", err_cnt); end
    if (sae !== 21'd0)        begin failures++; $display("[TB] FAIL exact_sae got=%0d exp=0", sae); end
    if (max_ed !== 5'd0)      begin failures++; $display("[TB] FAIL exact_max_ed got=%0d exp=0", max_ed); end
  endtask

  task automatic test_errors();
    pulse_start(16'd3);
    send_sample(8'h0B, 5'd9);
    send_sample(8'h19, 5'd10);
    send_sample(8'h1F, 5'd0);
    in_valid = 1'b0;
    wait_done();
    checks += 4;
    if (sample_cnt !== 16'd3) begin failures++; $display("[TB] FAIL err_sample_cnt got=%0d exp=3", sample_cnt); end
    if (err_cnt !== 16'd2)    begin failures++; $display("[TB] FAIL err_err_cnt got=%0d exp=2", err_cnt); end
    if (sae !== 21'd18)       begin failures++; $display("[TB] FAIL err_sae got=%0d exp=18", sae); end
    if (max_ed !== 5'd16)     begin failures++; $display("[TB] FAIL err_max_ed got=%0d exp=16", max_ed); end
`ifdef ADDER_ERR_EVAL_MSE_EN
    checks++;
    if (sse !== 26'd260)      begin failures++; $display("[TB] FAIL err_sse got=%0d exp=260", sse); end
`endif
  endtask

  // Gap cycles carry an FF/0 sample (ed=30) that must never be accumulated.
  task automatic test_toggle();
    int hs;
    int cyc;
    logic hit;
    hs  = 0;
    cyc = 0;
    pulse_start(16'd5);
    while (hs < 5 && cyc < 40) begin
      in_valid = ((cyc % 2) == 0);
      in_pi    = in_valid ? 8'h11 : 8'hFF;
      in_po    = 5'd0;
      hit      = in_valid && in_ready;
      tick();
      if (hit) hs++;
      cyc++;
    end
    checks++;
    if (hs != 5) begin failures++; $display("[TB] FAIL toggle_handshakes got=%0d exp=5", hs); end
    in_valid = 1'b1;
    in_pi    = 8'hFF;
    in_po    = 5'd0;
    checks += 2;
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL toggle_ready_after_last got=%0b exp=0", in_ready); end
    if (done !== 1'b0)     begin failures++; $display("[TB] FAIL toggle_done_plus0 got=%0b exp=0", done); end
    tick();
    checks++;
    if (done !== 1'b0)     begin failures++; $display("[TB] FAIL toggle_done_plus1 got=%0b exp=0", done); end
    tick();
    checks++;
    if (done !== 1'b1)     begin failures++; $display("[TB] FAIL toggle_done_plus2 got=%0b exp=1", done); end
    tick();
    tick();
    in_valid = 1'b0;
    checks += 5;
    if (done !== 1'b1)        begin failures++; $display("[TB] FAIL toggle_done_hold got=%0b exp=1", done); end
    if (sample_cnt !== 16'd5) begin failures++; $display("[TB] FAIL toggle_sample_cnt got=%0d exp=5", sample_cnt); end
    if (err_cnt !== 16'd5)    begin failures++; $display("[TB] FAIL toggle_err_cnt got=%0d exp=5", err_cnt); end
    if (sae !== 21'd10)       begin failures++; $display("[TB] FAIL toggle_sae got=%0d exp=10", sae); end
    if (max_ed !== 5'd2)      begin failures++; $display("[TB] FAIL toggle_max_ed got=%0d exp=2", max_ed); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1;
    in_pi    = 8'hFF;
    in_po    = 5'd0;
    pulse_start(16'd0);
    checks += 6;
    if (done !== 1'b1)      begin failures++; $display("[TB] FAIL zero_done got=%0b exp=1", done); end
    if (busy !== 1'b0)      begin failures++; $display("[TB] FAIL zero_busy got=%0b exp=0", busy); end
    if (in_ready !== 1'b0)  begin failures++; $display("[TB] FAIL zero_in_ready got=%0b exp=0", in_ready); end
    if (sample_cnt !== '0)  begin failures++; $display("[TB] FAIL zero_sample_cnt got=%0d exp=0", sample_cnt); end
    if (sae !== '0)         begin failures++; $display("[TB] FAIL zero_sae got=%0d exp=0", sae); end
    if (max_ed !== '0)      begin failures++; $display("[TB] FAIL zero_max_ed got=%0d exp=0", max_ed); end
    tick();
    tick();
    in_valid = 1'b0;
    checks += 2;
    if (sample_cnt !== '0)  begin failures++; $display("[TB] FAIL zero_hold_sample_cnt got=%0d exp=0", sample_cnt); end
    if (err_cnt !== '0)     begin failures++; $display("[TB] FAIL zero_err_cnt got=%0d exp=0", err_cnt); end
  endtask

  task automatic test_reset_midrun();
    pulse_start(16'd6);
    send_sample(8'hFF, 5'd0);
    send_sample(8'hFF, 5'd0);
    tick();
    rst         = 1'b1;
    start       = 1'b1;
    num_samples = 16'd4;
    in_valid    = 1'b1;
    tick();
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    checks += 6;
    if (busy !== 1'b0)     begin failures++; $display("[TB] FAIL mid_rst_busy got=%0b exp=0", busy); end
    if (done !== 1'b0)     begin failures++; $display("[TB] FAIL mid_rst_done got=%0b exp=0", done); end
    if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_in_ready got=%0b exp=0", in_ready); end
    if (sample_cnt !== '0) begin failures++; $display("[TB] FAIL mid_rst_sample_cnt got=%0d exp=0", sample_cnt); end
    if (sae !== '0)        begin failures++; $display("[TB] FAIL mid_rst_sae got=%0d exp=0", sae); end
    if (max_ed !== '0)     begin failures++; $display("[TB] FAIL mid_rst_max_ed got=%0d exp=0", max_ed); end
    tick();
    tick();
    checks++;
    if (sample_cnt !== '0) begin failures++; $display("[TB] FAIL mid_rst_no_inflight got=%0d exp=0", sample_cnt); end
    pulse_start(16'd1);
    send_sample(8'hFF, 5'd0);
    in_valid = 1'b0;
    wait_done();
    checks += 4;
    if (sample_cnt !== 16'd1) begin failures++; $display("[TB] FAIL mid_new_sample_cnt got=%0d exp=1", sample_cnt); end
    if (err_cnt !== 16'd1)    begin failures++; $display("[TB] FAIL mid_new_err_cnt got=%0d exp=1", err_cnt); end
    if (sae !== 21'd30)       begin failures++; $display("[TB] FAIL mid_new_sae got=%0d exp=30", sae); end
    if (max_ed !== 5'd30)     begin failures++; $display("[TB] FAIL mid_new_max_ed got=%0d exp=30", max_ed); end
  endtask

  task automatic test_restart_ignored();
    pulse_start(16'd3);
    send_sample(8'h21, 5'd3);
    in_valid = 1'b0;
    pulse_start(16'd7);
    send_sample(8'h21, 5'd3);
    send_sample(8'h21, 5'd4);
    in_valid = 1'b0;
    wait_done();
    checks += 5;
    if (sample_cnt !== 16'd3) begin failures++; $display("[TB] FAIL restart_sample_cnt got=%0d exp=3", sample_cnt); end
    if (err_cnt !== 16'd1)    begin failures++; $display("[TB] FAIL restart_err_cnt got=%0d exp=1", err_cnt); end
    if (sae !== 21'd1)        begin failures++; $display("[TB] FAIL restart_sae got=%0d exp=1", sae); end
    if (max_ed !== 5'd1)      begin failures++; $display("[TB] FAIL restart_max_ed got=%0d exp=1", max_ed); end
    if (in_ready !== 1'b0)    begin failures++; $display("[TB] FAIL restart_in_ready got=%0b exp=0", in_ready); end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    start       = 1'b0;
    num_samples = '0;
    in_valid    = 1'b0;
    in_pi       = '0;
    in_po       = '0;
    #1;
    test_reset();
    test_exact();
    test_errors();
    test_toggle();
    test_zero();
    test_reset_midrun();
    test_restart_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
